// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: drives a single DSP slice as a signed dot-product engine.
// Accepts a job length, streams operand pairs into the slice, tags each pair so the
// multiply/accumulate controls line up with the slice pipeline, and returns the
// accumulated sum once the last product has been folded into the slice result.
// Optional build macro: DSP_MAC_PERF_EN adds busy/stall performance counters.
module dsp_mac_sequencer #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_a,
  input  logic [DWIDTH-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              busy,
  output logic [DWIDTH-1:0] dsp_ax,
  output logic [DWIDTH-1:0] dsp_ay,
  output logic [DWIDTH-1:0] dsp_az,
  output logic              dsp_carry_in,
  output logic              dsp_multiply,
  output logic              dsp_accumulate,
  input  logic [DWIDTH-1:0] dsp_result
`ifdef DSP_MAC_PERF_EN
  ,
  output logic [31:0]       perf_busy_cycles,
  output logic [31:0]       perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // Per-pair tag travelling alongside the slice pipeline.
  typedef struct packed {
    logic v;
    logic first;
    logic last;
  } tag_t;

  state_t             state_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   idx_q;
  logic               drained_q;
  logic [DWIDTH-1:0]  out_data_q;
  tag_t               tag0_q, tag1_q;
  tag_t               tag0_d;

  logic               fire;
  logic               last_pair;

  assign in_ready  = (state_q == S_RUN);
  assign fire      = in_valid & in_ready;
  assign last_pair = (idx_q == (len_q - LEN_W'(1)));

  assign cfg_ready = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_data_q;

  // Slice operand ports: zero operands on non-fire cycles make a zero product,
  // which the accumulate control then folds in harmlessly as a bubble.
  assign dsp_ax       = '0;
  assign dsp_ay       = fire ? in_a : '0;
  assign dsp_az       = fire ? in_b : '0;
  assign dsp_carry_in = 1'b0;

  // Controls are taken from stage1, which lines up with the slice product register.
  assign dsp_multiply   = tag1_q.v & tag1_q.first;
  assign dsp_accumulate = ~(tag1_q.v & tag1_q.first);

  // Next tag entering stage0: describes the pair firing this cycle, empty otherwise.
  always_comb begin
    tag0_d       = '0;
    tag0_d.v     = fire;
    tag0_d.first = fire & (idx_q == '0);
    tag0_d.last  = fire & last_pair;
  end

  // Two-stage tag shift register tracking pairs through the slice.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag0_q <= '0;
      tag1_q <= '0;
    end else begin
      tag0_q <= tag0_d;
      tag1_q <= tag0_q;
    end
  end

  // Job sequencing FSM: accept config, count pairs, drain the slice, hold the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      drained_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_valid) begin
            idx_q     <= '0;
            drained_q <= 1'b0;
            if (cfg_len == '0) begin
              out_data_q <= '0;
              state_q    <= S_DONE;
            end else begin
              len_q   <= cfg_len;
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (fire) begin
            idx_q <= idx_q + LEN_W'(1);
            if (last_pair) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // The last-tagged entry leaving stage1 means the slice result is final
          // after that edge; it is captured one edge later.
          if (drained_q) begin
            out_data_q <= dsp_result;
            drained_q  <= 1'b0;
            state_q    <= S_DONE;
          end else if (tag1_q.v && tag1_q.last) begin
            drained_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef DSP_MAC_PERF_EN
  logic [31:0] perf_busy_q;
  logic [31:0] perf_stall_q;

  assign perf_busy_cycles  = perf_busy_q;
  assign perf_stall_cycles = perf_stall_q;

  // Saturating counters: cycles spent busy, and RUN cycles starved of input.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (busy && (perf_busy_q != '1)) begin
        perf_busy_q <= perf_busy_q + 32'd1;
      end
      if ((state_q == S_RUN) && !in_valid && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: behavioural DSP slice plus a dot-product reference.
module tb_dsp_mac_sequencer;
  localparam int DW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [LW-1:0] cfg_len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          busy;
  logic [DW-1:0] dsp_ax, dsp_ay, dsp_az;
  logic          dsp_carry_in, dsp_multiply, dsp_accumulate;
  logic [DW-1:0] dsp_result;
`ifdef DSP_MAC_PERF_EN
  logic [31:0]   perf_busy_cycles, perf_stall_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int op_a[0:15];
  int op_b[0:15];

  dsp_mac_sequencer #(.DWIDTH(DW), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy),
    .dsp_ax(dsp_ax), .dsp_ay(dsp_ay), .dsp_az(dsp_az),
    .dsp_carry_in(dsp_carry_in), .dsp_multiply(dsp_multiply),
    .dsp_accumulate(dsp_accumulate), .dsp_result(dsp_result)
`ifdef DSP_MAC_PERF_EN
    , .perf_busy_cycles(perf_busy_cycles), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] sat16(input int p);
    if (p > 32767) return 16'h7FFF;
    if (p < -32768) return 16'h8000;
    return p[15:0];
  endfunction

  // Behavioural DSP slice: registered inputs, saturated registered product, result register.
  logic signed [DW-1:0] sl_y, sl_z, sl_p, sl_r;
  always @(posedge clk) begin
    if (reset) begin
      sl_y <= '0; sl_z <= '0; sl_p <= '0; sl_r <= '0;
    end else begin
      sl_y <= dsp_ay;
      sl_z <= dsp_az;
      sl_p <= sat16(int'(sl_y) * int'(sl_z));
      if (dsp_multiply) sl_r <= sl_p;
      else if (dsp_accumulate) sl_r <= sl_r + sl_p;
    end
  end
  assign dsp_result = sl_r;

  // Reference: sum of saturated products, wrapped to 16 bits.
  function automatic logic [15:0] ref_dot(input int len);
    int acc;
    logic signed [15:0] sp;
    acc = 0;
    for (int i = 0; i < len; i++) begin
      sp = sat16(op_a[i] * op_b[i]);
      acc += sp;
    end
    return acc[15:0];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic check_reset_state(input string nm);
    check({nm, ":cfg_ready"}, 32'(cfg_ready), 1);
    check({nm, ":busy"}, 32'(busy), 0);
    check({nm, ":out_valid"}, 32'(out_valid), 0);
    check({nm, ":out_data"}, 32'(out_data), 0);
    check({nm, ":in_ready"}, 32'(in_ready), 0);
    check({nm, ":dsp_multiply"}, 32'(dsp_multiply), 0);
    check({nm, ":dsp_accumulate"}, 32'(dsp_accumulate), 1);
    check({nm, ":dsp_ay"}, 32'(dsp_ay), 0);
    check({nm, ":dsp_az"}, 32'(dsp_az), 0);
    check({nm, ":dsp_ax"}, 32'(dsp_ax), 0);
    check({nm, ":dsp_carry_in"}, 32'(dsp_carry_in), 0);
`ifdef DSP_MAC_PERF_EN
    check({nm, ":perf_busy"}, perf_busy_cycles, 0);
    check({nm, ":perf_stall"}, perf_stall_cycles, 0);
`endif
  endtask

  // One complete job; entered and left at a negedge with the DUT idle.
  task automatic run_job(input string nm, input int len, input int gap, input int hold,
                         input bit junk, input logic [15:0] exp);
    int e_cfg, e_last, e_exp, e_hs, tmo;
`ifdef DSP_MAC_PERF_EN
    logic [31:0] pb0, ps0;
    pb0 = perf_busy_cycles;
    ps0 = perf_stall_cycles;
`endif
    check({nm, ":cfg_ready_idle"}, 32'(cfg_ready), 1);
    cfg_valid = 1'b1;
    cfg_len   = LW'(len);
    e_cfg     = cyc + 1;
    e_last    = e_cfg;
    @(negedge clk);
    if (junk) cfg_len = 8'd5;
    else cfg_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (i > 0 && gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      in_valid = 1'b1;
      in_a = 16'(op_a[i]);
      in_b = 16'(op_b[i]);
      tmo = 0;
      while (!in_ready && tmo < 20) begin
        @(negedge clk);
        tmo++;
      end
      if (!in_ready) begin
        check({nm, ":in_ready_timeout"}, 0, 1);
        in_valid = 1'b0; cfg_valid = 1'b0;
        return;
      end
      e_last = cyc + 1;
      @(negedge clk);
    end
    in_valid = junk;
    in_a = 16'h1234;
    in_b = 16'h4321;
    e_exp = (len == 0) ? e_cfg : e_last + 3;
    tmo = 0;
    while (!out_valid && tmo < 20) begin
      @(negedge clk);
      tmo++;
    end
    in_valid = 1'b0;
    cfg_valid = 1'b0;
    if (!out_valid) begin
      check({nm, ":out_valid_timeout"}, 0, 1);
      return;
    end
    check({nm, ":latency_edge"}, 32'(cyc), 32'(e_exp));
    check({nm, ":out_data"}, 32'(out_data), 32'(exp));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({nm, ":hold_out_valid"}, 32'(out_valid), 1);
      check({nm, ":hold_out_data"}, 32'(out_data), 32'(exp));
      check({nm, ":hold_cfg_ready"}, 32'(cfg_ready), 0);
    end
    out_ready = 1'b1;
    e_hs = cyc + 1;
    @(negedge clk);
    out_ready = 1'b0;
    check({nm, ":post_cfg_ready"}, 32'(cfg_ready), 1);
    check({nm, ":post_out_valid"}, 32'(out_valid), 0);
`ifdef DSP_MAC_PERF_EN
    check({nm, ":perf_busy"}, perf_busy_cycles - pb0, 32'(e_hs - e_cfg));
    check({nm, ":perf_stall"}, perf_stall_cycles - ps0, 32'((len > 0) ? gap * (len - 1) : 0));
`endif
  endtask

  typedef struct packed {
    logic [7:0]       len;
    logic [7:0]       gap;
    logic [7:0]       hold;
    logic             junk;
    logic [2:0][15:0] a;
    logic [2:0][15:0] b;
    logic [15:0]      exp;
  } vec_t;

  vec_t vecs[0:7];

  task automatic set_vec(input int k, input int len, input int gap, input int hold, input bit junk,
                         input int a0, input int b0, input int a1, input int b1,
                         input int a2, input int b2, input logic [15:0] exp);
    vecs[k].len  = 8'(len);
    vecs[k].gap  = 8'(gap);
    vecs[k].hold = 8'(hold);
    vecs[k].junk = junk;
    vecs[k].a    = {16'(a2), 16'(a1), 16'(a0)};
    vecs[k].b    = {16'(b2), 16'(b1), 16'(b0)};
    vecs[k].exp  = exp;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [15:0] r16;
    int len, gap, hold;
    bit junk;

    set_vec(0, 3, 0, 0, 0,    2,     5,     3,     6,  -4, 1, 16'd24);
    set_vec(1, 3, 2, 1, 0,    2,     5,     3,     6,  -4, 1, 16'd24);
    set_vec(2, 1, 0, 0, 1,  300,   300,     0,     0,   0, 0, 16'h7FFF);
    set_vec(3, 1, 0, 0, 0,  300,  -300,     0,     0,   0, 0, 16'h8000);
    set_vec(4, 0, 0, 5, 0,    0,     0,     0,     0,   0, 0, 16'h0000);
    set_vec(5, 2, 1, 0, 1,  100,   100,   200,   200,   0, 0, 16'hA70F);
    set_vec(6, 2, 0, 2, 0, -32768, -32768, -32768, 1,   0, 0, 16'hFFFF);
    set_vec(7, 3, 1, 0, 1,   -7,     9,     0,     0,   5, -3, 16'hFFB2);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("init");

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 3; i++) begin
        r16 = vecs[k].a[i]; op_a[i] = r16;
        r16 = vecs[k].b[i]; op_b[i] = r16;
      end
      run_job($sformatf("vec%0d", k), int'(vecs[k].len), int'(vecs[k].gap),
              int'(vecs[k].hold), vecs[k].junk, vecs[k].exp);
    end

    // Reset mid-RUN after two of four pairs, then a fresh job must not see the old sum.
    cfg_valid = 1'b1;
    cfg_len = 8'd4;
    @(negedge clk);
    cfg_valid = 1'b0;
    in_valid = 1'b1; in_a = 16'd7; in_b = 16'd7;
    check("t5:in_ready0", 32'(in_ready), 1);
    @(negedge clk);
    in_a = 16'd8; in_b = 16'd8;
    check("t5:in_ready1", 32'(in_ready), 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_reset_state("t5_reset");
    op_a[0] = 1; op_b[0] = 1; op_a[1] = 2; op_b[1] = 2;
    run_job("t5_job", 2, 0, 0, 0, 16'd5);

    // Randomised jobs against the reference dot product.
    for (int j = 0; j < 30; j++) begin
      len  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
      gap  = int'($urandom_range(0, 2));
      hold = int'($urandom_range(0, 2));
      junk = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          r16 = 16'($urandom); op_a[i] = r16;
          r16 = 16'($urandom); op_b[i] = r16;
        end else begin
          op_a[i] = int'($urandom_range(0, 400)) - 200;
          op_b[i] = int'($urandom_range(0, 400)) - 200;
        end
      end
      run_job($sformatf("rand%0d", j), len, gap, hold, junk, ref_dot(len));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
